// File: rtl/alu_vec_sequencer.sv
// alu_vec_sequencer
//
// Processes one packed vector command lane by lane through a single shared
// scalar ALU. A command is accepted in IDLE, each lane is computed in one EXEC
// cycle, and the full result vector is presented in DONE until consumed.
//
// Optional feature: define ALU_VEC_SEQ_B2B_EN to accept a new command on the
// same edge that hands off the previous response (zero idle cycles between
// commands). When it is undefined, DONE always returns to IDLE first.
//
// Ports:
//   clk, rst       clock, asynchronous active-high reset
//   cmd_valid      command offered
//   cmd_ready      command accepted when cmd_valid && cmd_ready on a rising edge
//   cmd_select     opcode: ADD SUB AND OR XOR NOT SHL CMP (000..111)
//   cmd_a, cmd_b   packed operands, lane i at [i*WIDTH +: WIDTH]
//   rsp_valid      result vector available
//   rsp_ready      result consumed when rsp_valid && rsp_ready
//   rsp_data       lane i result at [i*8 +: 8]
//   rsp_carry      per-lane carry/borrow
//   busy           high in EXEC and DONE
//   lane_idx       lane being processed in EXEC, 0 otherwise
module alu_vec_sequencer #(
  parameter int unsigned WIDTH  = 4,
  parameter int unsigned N_LANE = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic [2:0]                  cmd_select,
  input  logic [WIDTH*N_LANE-1:0]     cmd_a,
  input  logic [WIDTH*N_LANE-1:0]     cmd_b,
  output logic                        rsp_valid,
  input  logic                        rsp_ready,
  output logic [8*N_LANE-1:0]         rsp_data,
  output logic [N_LANE-1:0]           rsp_carry,
  output logic                        busy,
  output logic [$clog2(N_LANE)-1:0]   lane_idx
);

  localparam int unsigned LaneW = $clog2(N_LANE);

  typedef enum logic [1:0] {StIdle, StExec, StDone} state_e;

  state_e                    state_q, state_d;
  logic [LaneW-1:0]          lane_q, lane_d;
  logic [2:0]                sel_q, sel_d;
  logic [WIDTH*N_LANE-1:0]   a_q, a_d, b_q, b_d;
  logic [8*N_LANE-1:0]       data_q, data_d;
  logic [N_LANE-1:0]         carry_q, carry_d;

  // Shared scalar ALU operating on the lane selected by lane_q
  logic [WIDTH-1:0] op_a, op_b, diff;
  logic [WIDTH:0]   sum, res_w;
  logic             is_cmp, alu_carry;
  logic             lt, eq, gt;
  logic [7:0]       alu_res;

  always_comb begin
    op_a      = a_q[int'(lane_q)*WIDTH +: WIDTH];
    op_b      = b_q[int'(lane_q)*WIDTH +: WIDTH];
    sum       = {1'b0, op_a} + {1'b0, op_b};
    diff      = op_a - op_b;
    lt        = op_a < op_b;
    eq        = op_a == op_b;
    gt        = op_a > op_b;
    res_w     = '0;
    alu_carry = 1'b0;
    is_cmp    = 1'b0;
    case (sel_q)
      3'b000: begin
        res_w     = sum;
        alu_carry = sum[WIDTH];
      end
      3'b001: begin
        res_w     = {1'b0, diff};
        alu_carry = lt;
      end
      3'b010: res_w = {1'b0, op_a & op_b};
      3'b011: res_w = {1'b0, op_a | op_b};
      3'b100: res_w = {1'b0, op_a ^ op_b};
      3'b101: res_w = {1'b0, ~op_a};
      3'b110: begin
        res_w     = {op_a, 1'b0};
        alu_carry = op_a[WIDTH-1];
      end
      default: is_cmp = 1'b1;
    endcase
    alu_res = is_cmp ? {5'b0, gt, eq, lt} : 8'(res_w);
  end

  always_comb begin
    state_d   = state_q;
    lane_d    = lane_q;
    sel_d     = sel_q;
    a_d       = a_q;
    b_d       = b_q;
    data_d    = data_q;
    carry_d   = carry_q;
    cmd_ready = 1'b0;
    unique case (state_q)
      StIdle: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          sel_d   = cmd_select;
          a_d     = cmd_a;
          b_d     = cmd_b;
          lane_d  = '0;
          state_d = StExec;
        end
      end
      StExec: begin
        data_d[int'(lane_q)*8 +: 8] = alu_res;
        carry_d[lane_q]             = alu_carry;
        if (lane_q == LaneW'(N_LANE - 1)) begin
          lane_d  = '0;
          state_d = StDone;
        end else begin
          lane_d = lane_q + LaneW'(1);
        end
      end
      StDone: begin
`ifdef ALU_VEC_SEQ_B2B_EN
        cmd_ready = rsp_ready;
        if (rsp_ready) begin
          if (cmd_valid) begin
            sel_d   = cmd_select;
            a_d     = cmd_a;
            b_d     = cmd_b;
            lane_d  = '0;
            state_d = StExec;
          end else begin
            state_d = StIdle;
          end
        end
`else
        if (rsp_ready) state_d = StIdle;
`endif
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      lane_q  <= '0;
      sel_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      data_q  <= '0;
      carry_q <= '0;
    end else begin
      state_q <= state_d;
      lane_q  <= lane_d;
      sel_q   <= sel_d;
      a_q     <= a_d;
      b_q     <= b_d;
      data_q  <= data_d;
      carry_q <= carry_d;
    end
  end

  assign rsp_valid = (state_q == StDone);
  assign busy      = (state_q != StIdle);
  assign lane_idx  = lane_q;
  assign rsp_data  = data_q;
  assign rsp_carry = carry_q;

endmodule

// File: doc/alu_vec_sequencer.md
ALU_VEC_SEQUENCER -- requirements
Module: alu_vec_sequencer

Interface
REQ-001 Parameter WIDTH, default 4, lane operand width in bits; legal range 1..7.
REQ-002 Parameter N_LANE, default 4, lanes per vector command; legal range 2..16.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset; asynchronous assertion, active-high.
REQ-005 cmd_valid  input  1  command offered.
REQ-006 cmd_ready  output  1  command accepted on a clk edge where cmd_valid && cmd_ready.
REQ-007 cmd_select  input  3  opcode: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 NOT a, 110 SHL a by 1, 111 CMP.
REQ-008 cmd_a, cmd_b  input  WIDTH*N_LANE  packed operands; lane i occupies bits [i*WIDTH +: WIDTH].
REQ-009 rsp_valid  output  1  result vector available.
REQ-010 rsp_ready  input  1  result consumed on an edge where rsp_valid && rsp_ready.
REQ-011 rsp_data  output  8*N_LANE  lane i result in bits [i*8 +: 8].
REQ-012 rsp_carry  output  N_LANE  per-lane carry/borrow flag.
REQ-013 busy  output  1  high in EXEC and DONE.
REQ-014 lane_idx  output  $clog2(N_LANE)  lane processed in the current EXEC cycle; 0 outside EXEC.

Function
REQ-015 FSM states IDLE, EXEC, DONE; exactly one active per cycle.
REQ-016 IDLE: cmd_ready=1; on acceptance, latch cmd_select/cmd_a/cmd_b, set lane_idx=0, go EXEC; otherwise remain in IDLE.
REQ-017 EXEC: cmd_ready=0; each cycle compute lane lane_idx from latched operands with a single shared scalar ALU, write rsp_data/rsp_carry slot lane_idx, increment lane_idx.
REQ-018 EXEC exit: on the edge that processes lane N_LANE-1, go DONE; no wrap of lane_idx occurs within a command.
REQ-019 Latency: rsp_valid rises exactly N_LANE cycles after the acceptance edge.
REQ-020 DONE: rsp_valid=1; rsp_data/rsp_carry held stable until rsp_ready; on rsp_ready go IDLE (macro-off behaviour).
REQ-021 cmd_valid is ignored in EXEC and DONE; latched operands are not disturbed by input changes.
REQ-022 ADD: result = zero-extended (WIDTH+1)-bit sum; carry = sum bit WIDTH.
REQ-023 SUB: result = zero-extended (a-b) mod 2^WIDTH; carry = 1 iff a<b (borrow).
REQ-024 AND/OR/XOR/NOT: zero-extended WIDTH-bit result; carry = 0.
REQ-025 SHL: result = zero-extended {a,1'b0}; carry = a[WIDTH-1].
REQ-026 CMP (unsigned): result = {5'b0, gt, eq, lt}, exactly one set; carry = 0.
REQ-027 Slots not yet written in the current command keep prior contents; only complete data is guaranteed when rsp_valid=1.

Reset
REQ-028 rst asserted: immediately state=IDLE, cmd_ready=1, rsp_valid=0, busy=0, lane_idx=0, rsp_data=0, rsp_carry=0, latched operands=0.
REQ-029 rst mid-EXEC or mid-DONE aborts the command; no rsp_valid is produced for it.
REQ-030 First acceptance possible on the first clk edge after rst deasserts.

Configuration
REQ-031 Macro ALU_VEC_SEQ_B2B_EN defined: in DONE, cmd_ready = rsp_ready; a command accepted in the same edge as the response hand-off goes directly to EXEC with lane_idx=0, giving zero idle cycles between commands.
REQ-032 Macro undefined: cmd_ready=0 in DONE; at least one IDLE cycle between commands.

Verification
REQ-033 WIDTH=4, N_LANE=4, ADD a=16'hF321, b=16'h1111 -> after 4 cycles rsp_data=32'h10040302, rsp_carry=4'b1000.
REQ-034 SUB a=16'h3005, b=16'h4003 -> rsp_data=32'h0F000002, rsp_carry=4'b1000.
REQ-035 CMP a=16'h1234, b=16'h2214 -> rsp_data=32'h01020402, rsp_carry=4'b0000.
REQ-036 rsp_ready held 0 for 5 cycles in DONE, cmd_valid=1 with changing operands -> rsp_valid stays 1, rsp_data unchanged, cmd_ready=0, no acceptance.
REQ-037 rst pulsed when lane_idx=2 -> same cycle: rsp_valid=0, cmd_ready=1, busy=0, rsp_data=0; no later response for aborted command.
REQ-038 B2B_EN defined, cmd_valid and rsp_ready both 1 in DONE -> second command accepted that edge, its rsp_valid exactly 4 cycles later; B2B_EN undefined -> one IDLE cycle inserted, 5 cycles.
